fpu_div_frac_iter: RTL and testbench
====================================

// Module: fpu_div_frac_iter
// PURPOSE
//  Iterative radix-2 restoring divider for the divide pipe's fraction datapath; computes in1/in2.
//  Takes normalized 53b fractions from the divide input stage and emits MSB-aligned quotient bits
//  plus a sticky bit to the shared round/output logic, in the same format the multiply pipe feeds it.
//  Single-issue; one quotient bit per enabled cycle.
// PARAMETERS
//  FW    53  fraction width incl. hidden bit
//  QW    56  output width: 55 quotient bits + sticky
//  NQ_D  55  quotient bits, double
//  NQ_S  26  quotient bits, single (24 + guard + 1 for quotient < 1)
// PORTS
//  rclk          in   1   global clock; one clock domain
//  arst_l        in   1   reset, asynchronous, active-low
//  div_step      in   1   advance enable; low = hold all state (stall)
//  div_start     in   1   request; sampled only in IDLE with div_step=1
//  div_kill      in   1   flush in-flight op
//  div_dblop     in   1   1=double (in[52:0]), 0=single (in[52:29], [28:0]=0)
//  div_frac_in1  in   53  dividend, bit52=1
//  div_frac_in2  in   53  divisor, bit52=1
//  div_busy      out  1   state != IDLE
//  div_done      out  1   1-cycle result-valid pulse
//  div_frac_out  out  56  [55:1] quotient (bit55 weight 2^0), [0] sticky (remainder != 0)
// BEHAVIOUR
//  - Reset (async, arst_l=0): state=IDLE; div_busy=0, div_done=0, div_frac_out=0; rem/divisor/count cleared.
//  - FSM IDLE->ITER->DONE->IDLE. All transitions qualified by div_step=1; div_step=0 freezes state, count, rem, outputs.
//  - IDLE: div_start -> load rem={1'b0,in1} (54b), dvsr=in2, q=0, cnt=(dblop?NQ_D:NQ_S)-1; go ITER.
//  - ITER, per step: if rem>=dvsr {qbit=1; rem-=dvsr} else qbit=0; rem<<=1; q shifts qbit in;
//    cnt==0 -> DONE, else cnt--.
//  - DONE: div_done=1 for exactly one step cycle; div_frac_out = q MSB-aligned at [55:56-NQ], lower quotient bits 0,
//    [0]=|rem. Next state IDLE. div_frac_out holds until the next DONE or reset.
//  - Latency (no stalls): start sampled at cycle C; div_done high at C+56 (dbl), C+27 (sng).
//  - div_start while busy: ignored; no queuing. Start and DONE in the same cycle: ignored (state is not IDLE).
//  - div_kill: ITER/DONE -> IDLE at the next edge regardless of div_step; no div_done; div_frac_out unchanged.
//    Kill wins over start in the same cycle.
//  - Widths: rem is 54b so rem<2*dvsr always holds; subtract has no borrow-out by construction (assert in sim).
// CONFIGURATION
//  FPU_DIV_EARLY_TERM_EN defined: in ITER, if rem becomes 0 after a step, go DONE next cycle;
//    remaining quotient bits 0, sticky 0; latency becomes data-dependent (min C+2).
//  Undefined: fixed latency as above; no zero-remainder detect in the FSM.
// STRUCTURE
//  - Shared package fpu_div_pkg: state encoding (IDLE/ITER/DONE), FW, QW, NQ_D, NQ_S constants.
//  - One sub-module fpu_div_frac_step: combinational compare/subtract/shift of one restoring step
//    (rem, dvsr -> rem_nxt, qbit). Top holds FSM, counter, q shift register, output register.
//  - All flops async-reset on arst_l; clocked on rclk.
// TESTING
//  1. dbl 53'h10000000000000 / 53'h10000000000000, start at C -> done at C+56, out=56'h80_0000_0000_0000.
//  2. dbl 53'h10000000000000 / 53'h18000000000000 -> out=56'h55_5555_5555_5555 (2/3, sticky=1).
//  3. sng 53'h18000000000000 / 53'h10000000000000 -> done at C+27, out=56'hC0_0000_0000_0000.
//  4. case 1 with div_step=0 for 10 cycles mid-ITER -> done at C+66; same out; start pulses while busy are ignored.
//  5. div_kill at C+20 -> busy=0 at C+21, no done; new start at C+22 -> correct result at C+78.
//  6. arst_l low at C+30 -> busy, done, out =0 immediately. EARLY_TERM build: case 1 done at C+2, same out.

Source files
------------

// File: rtl/fpu_div_pkg.sv
// Shared constants and state encoding for the divide-pipe fraction iterator.
package fpu_div_pkg;

    localparam int FW   = 53;
    localparam int QW   = 56;
    localparam int NQ_D = 55;
    localparam int NQ_S = 26;
    localparam int CW   = 6;

    localparam logic [CW-1:0] CNT_D = CW'(NQ_D - 1);
    localparam logic [CW-1:0] CNT_S = CW'(NQ_S - 1);

    // Single-precision fractions occupy the top 24 bits of the 53-bit field.
    localparam logic [FW-1:0] SNG_MASK = {{24{1'b1}}, {(FW-24){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/fpu_div_frac_step.sv
// One restoring-division step: compare/subtract the divisor, then shift the
// partial remainder left by one.
module fpu_div_frac_step
    import fpu_div_pkg::*;
(
    input  logic [FW:0]   rem,
    input  logic [FW-1:0] dvsr,
    output logic [FW:0]   rem_nxt,
    output logic          qbit
);

    logic [FW+1:0] diff;
    logic          ge;
    logic [FW:0]   part;

    assign diff    = {1'b0, rem} - {2'b00, dvsr};
    assign ge      = ~diff[FW+1];
    assign part    = ge ? diff[FW:0] : rem;
    assign rem_nxt = {part[FW-1:0], 1'b0};
    assign qbit    = ge;

    // rem < 2*dvsr on entry keeps the restored remainder below 2^53, so the shift loses nothing.
    always_comb begin
        assert (part[FW] == 1'b0);
    end

endmodule

// File: rtl/fpu_div_frac_iter.sv
// Iterative radix-2 restoring fraction divider (in1/in2), one quotient bit per enabled cycle.
// Optional feature: FPU_DIV_EARLY_TERM_EN ends iteration as soon as the remainder reaches zero.
module fpu_div_frac_iter
    import fpu_div_pkg::*;
(
    input  logic          rclk,
    input  logic          arst_l,
    input  logic          div_step,
    input  logic          div_start,
    input  logic          div_kill,
    input  logic          div_dblop,
    input  logic [FW-1:0] div_frac_in1,
    input  logic [FW-1:0] div_frac_in2,
    output logic          div_busy,
    output logic          div_done,
    output logic [QW-1:0] div_frac_out
);

    div_state_e      state_q;
    logic [FW:0]     rem_q;
    logic [FW-1:0]   dvsr_q;
    logic [CW-1:0]   cnt_q;
    logic [NQ_D-1:0] q_q;
    logic [NQ_D-1:0] qmask_q;
    logic            done_q;
    logic [QW-1:0]   out_q;

    logic [FW:0]     step_rem;
    logic            step_qbit;
    logic            iter_last;
    logic [FW-1:0]   in_mask;
    logic [FW:0]     rem_d;
    logic [FW-1:0]   dvsr_d;
    logic [CW-1:0]   cnt_d;

    fpu_div_frac_step u_step (
        .rem     (rem_q),
        .dvsr    (dvsr_q),
        .rem_nxt (step_rem),
        .qbit    (step_qbit)
    );

`ifdef FPU_DIV_EARLY_TERM_EN
    assign iter_last = (cnt_q == '0) || (step_rem == '0);
`else
    assign iter_last = (cnt_q == '0);
`endif

    assign in_mask = div_dblop ? {FW{1'b1}} : SNG_MASK;
    assign rem_d   = {1'b0, div_frac_in1 & in_mask};
    assign dvsr_d  = div_frac_in2 & in_mask;
    assign cnt_d   = div_dblop ? CNT_D : CNT_S;

    // The quotient is built MSB-first through a walking one-hot mask, so it is
    // already MSB-aligned with unfilled low bits zero whenever iteration stops.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            qmask_q <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else if (div_kill && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else if (div_step) begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (div_start) begin
                        rem_q   <= rem_d;
                        dvsr_q  <= dvsr_d;
                        cnt_q   <= cnt_d;
                        q_q     <= '0;
                        qmask_q <= {1'b1, {(NQ_D-1){1'b0}}};
                        state_q <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    rem_q   <= step_rem;
                    q_q     <= step_qbit ? (q_q | qmask_q) : q_q;
                    qmask_q <= qmask_q >> 1;
                    if (iter_last) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    out_q   <= {q_q, |rem_q};
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_busy     = (state_q != ST_IDLE);
    assign div_done     = done_q;
    assign div_frac_out = out_q;

endmodule

// File: tb/tb_fpu_div_frac_iter.sv
// Directed bench for fpu_div_frac_iter: results, latency, stall, kill and async reset.
module tb_fpu_div_frac_iter;

    logic        rclk;
    logic        arst_l;
    logic        div_step;
    logic        div_start;
    logic        div_kill;
    logic        div_dblop;
    logic [52:0] div_frac_in1;
    logic [52:0] div_frac_in2;
    logic        div_busy;
    logic        div_done;
    logic [55:0] div_frac_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0     = 0;

    localparam logic [52:0] ONE   = 53'h10000000000000;
    localparam logic [52:0] ONEP5 = 53'h18000000000000;
    localparam logic [55:0] EXP1  = 56'h80000000000000;
    localparam logic [55:0] EXP2  = 56'h55555555555555;
    localparam logic [55:0] EXP3  = 56'hC0000000000000;
`ifdef FPU_DIV_EARLY_TERM_EN
    localparam int LAT1 = 2;
    localparam int LAT3 = 3;
`else
    localparam int LAT1 = 56;
    localparam int LAT3 = 27;
`endif
    localparam int LAT2 = 56;

    fpu_div_frac_iter dut (
        .rclk         (rclk),
        .arst_l       (arst_l),
        .div_step     (div_step),
        .div_start    (div_start),
        .div_kill     (div_kill),
        .div_dblop    (div_dblop),
        .div_frac_in1 (div_frac_in1),
        .div_frac_in2 (div_frac_in2),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_frac_out (div_frac_out)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    always @(posedge rclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Present a start so that it is sampled at the next edge (cycle C); returns just after C.
    task automatic start_op(input logic dbl, input logic [52:0] a, input logic [52:0] b);
        @(negedge rclk);
        div_dblop    = dbl;
        div_frac_in1 = a;
        div_frac_in2 = b;
        div_start    = 1'b1;
        div_step     = 1'b1;
        @(posedge rclk);
        #1;
        c0 = cyc;
        @(negedge rclk);
        div_start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [55:0] res);
        lat = -1;
        res = '0;
        for (int i = 0; i < 300; i++) begin
            @(posedge rclk);
            #1;
            if (div_done) begin
                lat = cyc - c0;
                res = div_frac_out;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic dbl, input logic [52:0] a,
                          input logic [52:0] b, input int exp_lat, input logic [55:0] exp_out);
        int          lat;
        logic [55:0] res;
        start_op(dbl, a, b);
        check({tag, "_busy"}, 64'(div_busy), 64'(1));
        wait_done(lat, res);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_out"}, 64'(res), 64'(exp_out));
        @(posedge rclk);
        #1;
        check({tag, "_pulse"}, 64'(div_done), 64'(0));
        check({tag, "_idle"}, 64'(div_busy), 64'(0));
        $display("op %s lat %0d out %h", tag, lat, res);
    endtask

    initial begin
        int          lat;
        int          extra;
        logic [55:0] res;

        arst_l       = 1'b0;
        div_step     = 1'b1;
        div_start    = 1'b0;
        div_kill     = 1'b0;
        div_dblop    = 1'b1;
        div_frac_in1 = '0;
        div_frac_in2 = '0;
        #2;
        check("rst_busy", 64'(div_busy), 64'(0));
        check("rst_done", 64'(div_done), 64'(0));
        check("rst_out", 64'(div_frac_out), 64'(0));
        repeat (3) @(negedge rclk);
        arst_l = 1'b1;

        run_op("dbl_1_1", 1'b1, ONE, ONE, LAT1, EXP1);
        run_op("dbl_1_1p5", 1'b1, ONE, ONEP5, LAT2, EXP2);
        run_op("sng_1p5_1", 1'b0, ONEP5, ONE, LAT3, EXP3);

        // Stall 10 cycles mid-iteration with start pulses that must be ignored.
        start_op(1'b1, ONE, ONEP5);
        repeat (9) @(negedge rclk);
        div_step  = 1'b0;
        div_start = 1'b1;
        repeat (10) @(negedge rclk);
        check("stall_busy", 64'(div_busy), 64'(1));
        check("stall_done", 64'(div_done), 64'(0));
        div_step = 1'b1;
        repeat (3) @(negedge rclk);
        div_start = 1'b0;
        wait_done(lat, res);
        check("stall_lat", 64'(lat), 64'(LAT2 + 10));
        check("stall_out", 64'(res), 64'(EXP2));
        $display("op stall lat %0d out %h", lat, res);
        extra = 0;
        repeat (70) begin
            @(posedge rclk);
            #1;
            extra += int'(div_done);
        end
        check("stall_noqueue", 64'(extra), 64'(0));

        // Kill mid-iteration, then restart two cycles later.
        start_op(1'b1, ONEP5, ONEP5);
        repeat (20) @(negedge rclk);
        check("kill_busy_pre", 64'(div_busy), 64'(1));
        div_kill = 1'b1;
        @(posedge rclk);
        #1;
        check("kill_busy", 64'(div_busy), 64'(0));
        check("kill_done", 64'(div_done), 64'(0));
        check("kill_out", 64'(div_frac_out), 64'(EXP2));
        div_kill = 1'b0;
        start_op(1'b1, ONE, ONE);
        wait_done(lat, res);
        check("kill_restart_lat", 64'(lat), 64'(LAT1));
        check("kill_restart_out", 64'(res), 64'(EXP1));
        $display("op kill_restart lat %0d out %h", lat, res);

        // Async reset in the middle of an operation clears outputs immediately.
        run_op("pre_rst", 1'b0, ONEP5, ONE, LAT3, EXP3);
        start_op(1'b1, ONE, ONEP5);
        repeat (29) @(negedge rclk);
        check("arst_busy_pre", 64'(div_busy), 64'(1));
        #2;
        arst_l = 1'b0;
        #1;
        check("arst_busy", 64'(div_busy), 64'(0));
        check("arst_done", 64'(div_done), 64'(0));
        check("arst_out", 64'(div_frac_out), 64'(0));
        $display("op async_reset busy %0d done %0d out %h", div_busy, div_done, div_frac_out);
        @(negedge rclk);
        arst_l = 1'b1;
        repeat (5) @(posedge rclk);
        #1;
        check("arst_idle", 64'(div_busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
